div_result_capture: RTL and testbench
=====================================

# div_result_capture

Posedge-domain receiver for divider results launched on the falling clock edge. The divider core drives quotient, remainder and divide-by-zero flag through negative-edge output buffers, so they are stable half a cycle before the next rising edge. This block samples them on the rising edge into a 2-entry buffer and hands them to the posedge consumer with a valid/ready handshake. It also detects results the producer pushes while the buffer is full.

## Interface
- WIDTH, 32, bit width of quotient and remainder.

- clk  input  1  single clock; all block state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  result present on in_* this cycle; negedge-launched by the producer.
- in_quot  input  WIDTH  quotient.
- in_rem  input  WIDTH  remainder.
- in_dbz  input  1  divide-by-zero flag.
- in_ready  output  1  buffer can accept; combinational from occupancy only (count < 2).
- out_valid  output  1  head entry valid.
- out_quot  output  WIDTH  head quotient.
- out_rem  output  WIDTH  head remainder.
- out_dbz  output  1  head divide-by-zero flag.
- out_ready  input  1  consumer accepts head this cycle.
- ovf_err  output  1  sticky: a result arrived while the buffer was full.
- err_clr  input  1  synchronous clear of ovf_err.
- result_cnt  output  16  accepted-result counter; present only with DIV_CAPTURE_CNT_EN.

## Operation
- Storage: two entries, each {quot, rem, dbz}. Head and tail pointers are 1 bit each. Occupancy count is 0..2.
- Occupancy states:
  - EMPTY (count 0): out_valid=0, in_ready=1.
  - ONE (count 1): out_valid=1, in_ready=1.
  - FULL (count 2): out_valid=1, in_ready=0.
- Push: in_valid && count<2. Writes in_* to the tail entry, tail++.
- Pop: out_valid && out_ready. head++.
- Count update: push only +1; pop only -1; push and pop in the same cycle leaves count unchanged.
- Push and pop together are legal in ONE, and in EMPTY→ONE→… sequences as expected. In ONE, count stays 1 and the head advances to the newly written entry.
- A push into EMPTY with out_ready=1 does not bypass the buffer. The data is visible on out_* only from the next cycle.
- Drop: in_valid && count==2.
  - Data is discarded and the buffer is unchanged.
  - ovf_err is set on the next edge.
  - A pop in the same cycle still occurs; the dropped result is not admitted.
- ovf_err:
  - Stays set until err_clr is sampled high.
  - If a drop and err_clr occur in the same cycle, set wins.
- out_* reflect the head entry. When out_valid=0, out_quot/out_rem/out_dbz hold the last popped entry's stored values.
- Pointer wrap: 1-bit pointers wrap 1→0 naturally.

## Timing
- Reset (rst_n low, asynchronous):
  - count=0, pointers=0, all entries=0, ovf_err=0, result_cnt=0.
  - Hence out_valid=0, out_quot=0, out_rem=0, out_dbz=0, in_ready=1.
- Release: the first push is possible on the first rising edge with rst_n high.
- Latency: in_valid sampled at edge N → out_valid=1 and data on out_* after edge N. Minimum latency is 1 cycle.
- Throughput: 1 result per cycle sustained when out_ready is held high.
- Input sampling: in_* are sampled only at the rising edge, and only when a push occurs. The producer may change them at any falling edge.
- Reset mid-operation: all entries are lost, no pop is reported, and ovf_err clears.

## Configuration
- DIV_CAPTURE_CNT_EN defined:
  - result_cnt port and its 16-bit register exist.
  - The register increments on every push and wraps 0xFFFF→0x0000.
  - Drops do not count.
  - It resets to 0.
- Not defined: the port and register are absent. All other behaviour is identical.

## Test plan
- Reset then single push of quot=0x0000_0007, rem=0x3, dbz=0 with out_ready=1:
  - Edge after push: out_valid=1 with those values.
  - Next edge: out_valid=0.
  - in_ready is 1 throughout.
- out_ready=0, push 0xA then 0xB:
  - in_ready=0 after the second push.
  - Pushing 0xC: ovf_err=1, and out pops in order 0xA, 0xB (0xC never appears).
- FULL state with simultaneous in_valid and out_ready:
  - Head pops and ovf_err is set.
  - Next cycle count=1, and err_clr=1 with no drop clears ovf_err.
- Streaming 8 results with out_ready=1 every cycle:
  - All 8 delivered in order, one per cycle.
  - in_ready never falls.
  - result_cnt=8 with the macro.
- Push while ONE with a pop in the same cycle:
  - Count stays 1 and the new head equals the pushed value.
  - A drop and err_clr in the same cycle leaves ovf_err=1.
- Assert rst_n low mid-burst with count=2:
  - Outputs go to 0 immediately, without waiting for an edge.
  - After release, the first push behaves as from reset.
  - result_cnt=0.

Source files
------------

// File: rtl/div_result_capture.sv
// Posedge capture of negedge-launched divider results into a 2-entry buffer.
// Optional DIV_CAPTURE_CNT_EN adds the 16-bit result_cnt port.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/quot/rem/dbz producer side, sampled on push only
//   in_ready              occupancy < 2
//   out_valid/quot/rem/dbz head entry to consumer
//   out_ready             consumer takes head
//   ovf_err, err_clr      sticky drop flag and its clear
//   result_cnt            accepted-result counter (DIV_CAPTURE_CNT_EN)
module div_result_capture #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_quot,
  input  logic [WIDTH-1:0] in_rem,
  input  logic             in_dbz,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_dbz,
  input  logic             out_ready,
  output logic             ovf_err,
  input  logic             err_clr
`ifdef DIV_CAPTURE_CNT_EN
  ,
  output logic [15:0]      result_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t state;
  occ_t state_nx;

  logic             head;
  logic             tail;
  logic [WIDTH-1:0] quot_q [2];
  logic [WIDTH-1:0] rem_q  [2];
  logic             dbz_q  [2];

  logic push;
  logic pop;
  logic drop;
  logic rd;

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    unique case (state)
      EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
      end
      FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
    push = in_valid && in_ready;
    pop  = out_valid && out_ready;
    drop = in_valid && !in_ready;
    unique case (1'b1)
      push && !pop:
        state_nx = (state == EMPTY) ? ONE : FULL;
      pop && !push:
        state_nx = (state == FULL) ? ONE : EMPTY;
      default:
        state_nx = state;
    endcase
  end

  // When empty, head sits one past the last popped entry, and that
  // slot cannot be rewritten until the next push lands at head.
  assign rd       = out_valid ? head : ~head;
  assign out_quot = quot_q[rd];
  assign out_rem  = rem_q[rd];
  assign out_dbz  = dbz_q[rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      head      <= 1'b0;
      tail      <= 1'b0;
      quot_q[0] <= '0;
      quot_q[1] <= '0;
      rem_q[0]  <= '0;
      rem_q[1]  <= '0;
      dbz_q[0]  <= 1'b0;
      dbz_q[1]  <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) begin
        quot_q[tail] <= in_quot;
        rem_q[tail]  <= in_rem;
        dbz_q[tail]  <= in_dbz;
        tail         <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      if (drop) begin
        ovf_err <= 1'b1;
      end else if (err_clr) begin
        ovf_err <= 1'b0;
      end
    end
  end

`ifdef DIV_CAPTURE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_cnt <= 16'd0;
    end else if (push) begin
      result_cnt <= result_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_div_result_capture.sv
// Bench for div_result_capture: queue model, directed and random phases.
// Inputs change on negedge; outputs compared on negedge.
module tb_div_result_capture;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_quot;
  logic [W-1:0] in_rem;
  logic         in_dbz;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_quot;
  logic [W-1:0] out_rem;
  logic         out_dbz;
  logic         out_ready;
  logic         ovf_err;
  logic         err_clr;
`ifdef DIV_CAPTURE_CNT_EN
  logic [15:0]  result_cnt;
`endif

  div_result_capture #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_quot    (in_quot),
    .in_rem     (in_rem),
    .in_dbz     (in_dbz),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_quot   (out_quot),
    .out_rem    (out_rem),
    .out_dbz    (out_dbz),
    .out_ready  (out_ready),
    .ovf_err    (ovf_err),
    .err_clr    (err_clr)
`ifdef DIV_CAPTURE_CNT_EN
    ,
    .result_cnt (result_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         d;
  } ent_t;

  ent_t        mq[$];
  ent_t        last;
  logic        m_ovf;
  logic [15:0] m_cnt;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    last  = '{q: '0, r: '0, d: 1'b0};
    m_ovf = 1'b0;
    m_cnt = 16'd0;
  endtask

  // Applied at each rising edge with the inputs that were set up for it.
  task automatic model_update();
    int  n;
    bit  pop_e;
    bit  push_e;
    bit  drop_e;
    ent_t e;
    if (!rst_n) begin
      model_reset();
      return;
    end
    n      = mq.size();
    pop_e  = (n > 0) && out_ready;
    push_e = in_valid && (n < 2);
    drop_e = in_valid && (n == 2);
    if (pop_e) last = mq.pop_front();
    if (push_e) begin
      e = '{q: in_quot, r: in_rem, d: in_dbz};
      mq.push_back(e);
      m_cnt = m_cnt + 16'd1;
    end
    if (drop_e) m_ovf = 1'b1;
    else if (err_clr) m_ovf = 1'b0;
  endtask

  task automatic model_check();
    ent_t h;
    h = (mq.size() > 0) ? mq[0] : last;
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    chk("out_quot", 64'(out_quot), 64'(h.q));
    chk("out_rem", 64'(out_rem), 64'(h.r));
    chk("out_dbz", 64'(out_dbz), 64'(h.d));
    chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
`ifdef DIV_CAPTURE_CNT_EN
    chk("result_cnt", 64'(result_cnt), 64'(m_cnt));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    model_check();
  endtask

  task automatic drv(logic iv, logic [W-1:0] q, logic [W-1:0] r,
                     logic d, logic ordy, logic clr);
    in_valid  = iv;
    in_quot   = q;
    in_rem    = r;
    in_dbz    = d;
    out_ready = ordy;
    err_clr   = clr;
  endtask

  initial begin
    rst_n = 1'b0;
    drv(0, '0, '0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_quot", 64'(out_quot), 64'd0);
    chk("rst ovf", 64'(ovf_err), 64'd0);
    model_check();
    rst_n = 1'b1;

    // single push, immediate consumer
    drv(1, 32'h7, 32'h3, 0, 1, 0);
    cycle();
    chk("t1 valid", 64'(out_valid), 64'd1);
    chk("t1 quot", 64'(out_quot), 64'h7);
    chk("t1 rem", 64'(out_rem), 64'h3);
    chk("t1 ready", 64'(in_ready), 64'd1);
    drv(0, '0, '0, 0, 1, 0);
    cycle();
    chk("t1 gone", 64'(out_valid), 64'd0);

    // fill, drop, drain in order
    drv(1, 32'hA, 32'h1, 0, 0, 0);
    cycle();
    drv(1, 32'hB, 32'h2, 1, 0, 0);
    cycle();
    chk("t2 full", 64'(in_ready), 64'd0);
    drv(1, 32'hC, 32'h3, 0, 0, 0);
    cycle();
    chk("t2 ovf", 64'(ovf_err), 64'd1);
    chk("t2 head A", 64'(out_quot), 64'hA);
    drv(0, '0, '0, 0, 1, 0);
    cycle();
    chk("t2 head B", 64'(out_quot), 64'hB);
    chk("t2 dbz B", 64'(out_dbz), 64'd1);
    cycle();
    chk("t2 empty", 64'(out_valid), 64'd0);
    chk("t2 hold B", 64'(out_quot), 64'hB);

    // full with push and pop together, then clear
    drv(0, '0, '0, 0, 0, 1);
    cycle();
    chk("t3 clr", 64'(ovf_err), 64'd0);
    drv(1, 32'hA, 32'h0, 0, 0, 0);
    cycle();
    drv(1, 32'hB, 32'h0, 0, 0, 0);
    cycle();
    drv(1, 32'hD, 32'h0, 0, 1, 0);
    cycle();
    chk("t3 ovf", 64'(ovf_err), 64'd1);
    chk("t3 head", 64'(out_quot), 64'hB);
    chk("t3 one", 64'(in_ready), 64'd1);
    drv(0, '0, '0, 0, 0, 1);
    cycle();
    chk("t3 clr2", 64'(ovf_err), 64'd0);

    // streaming 8
    drv(0, '0, '0, 0, 1, 0);
    cycle();
    for (int i = 0; i < 8; i++) begin
      drv(1, 32'h100 + 32'(i), 32'(i), 0, 1, 0);
      cycle();
      chk("t4 stream", 64'(out_quot), 64'h100 + 64'(i));
      chk("t4 ready", 64'(in_ready), 64'd1);
    end
    drv(0, '0, '0, 0, 1, 0);
    cycle();
    chk("t4 last", 64'(out_quot), 64'h107);
`ifdef DIV_CAPTURE_CNT_EN
    chk("t4 cnt", 64'(result_cnt), 64'd13);
`endif

    // push+pop in ONE, drop with clear
    drv(1, 32'h21, 32'h0, 0, 0, 0);
    cycle();
    drv(1, 32'h22, 32'h0, 0, 1, 0);
    cycle();
    chk("t5 head", 64'(out_quot), 64'h22);
    chk("t5 one", 64'(in_ready), 64'd1);
    drv(1, 32'h23, 32'h0, 0, 0, 0);
    cycle();
    drv(1, 32'h24, 32'h0, 0, 0, 1);
    cycle();
    chk("t5 set wins", 64'(ovf_err), 64'd1);

    // async reset while full
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 valid", 64'(out_valid), 64'd0);
    chk("t6 quot", 64'(out_quot), 64'd0);
    chk("t6 ready", 64'(in_ready), 64'd1);
    chk("t6 ovf", 64'(ovf_err), 64'd0);
    model_reset();
    drv(0, '0, '0, 0, 0, 0);
    cycle();
    rst_n = 1'b1;
    drv(1, 32'h55, 32'h5, 1, 0, 0);
    cycle();
    chk("t6 push", 64'(out_quot), 64'h55);
`ifdef DIV_CAPTURE_CNT_EN
    chk("t6 cnt", 64'(result_cnt), 64'd1);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drv(logic'($urandom_range(0, 9) < 6), $urandom(), $urandom(),
          logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 9) == 0));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
